// File: rtl/result_reader.sv
// ---------------------------------------------------------------------------
// result_reader
//
// Reads back word pairs that the forward pass stored in the dual-port result
// memory. Each pair is fetched from two consecutive addresses in one memory
// cycle and buffered. The two words are then streamed out one per beat on a
// valid/ready interface, with the port-1 word first and the port-2 word second.
//
// Parameters
//   DWIDTH  data word width (signed fixed point, passed through untouched)
//   frac    fractional bits of the data format (documentation only)
//   AWIDTH  memory address width
//   CWIDTH  width of the pair-count input
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-low reset
//   start              one-cycle transfer request, honoured only when idle
//   base_addr          address of the first port-1 word
//   pair_count         number of pairs to move (0 gives an empty transfer)
//   mem_en             memory read enable
//   mem_addr1/2        read addresses; these hold while mem_en is low
//   mem_data1/2        read data, valid the cycle after mem_en
//   m_data/m_valid/
//   m_ready/m_last     output stream; m_last marks the final word
//   busy               high from start acceptance until the done pulse
//   done               one-cycle pulse when a transfer finishes
// ---------------------------------------------------------------------------
module result_reader #(
  parameter int DWIDTH = 32,
  parameter int frac   = 24,
  parameter int AWIDTH = 8,
  parameter int CWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [CWIDTH-1:0] pair_count,
  output logic              mem_en,
  output logic [AWIDTH-1:0] mem_addr1,
  output logic [AWIDTH-1:0] mem_addr2,
  input  logic [DWIDTH-1:0] mem_data1,
  input  logic [DWIDTH-1:0] mem_data2,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  // The data format must keep at least one integer bit. Nothing else in this
  // block depends on the binary point.
  if (frac >= DWIDTH) begin : g_bad_frac
    $error("result_reader: frac must be smaller than DWIDTH");
  end

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    SEND1,
    SEND2,
    DONE
  } state_t;

  state_t              state_q, state_n;
  logic [AWIDTH-1:0]   addr_q, addr_n;
  logic [CWIDTH-1:0]   remaining_q, remaining_n;
  logic [DWIDTH-1:0]   buf2_q, buf2_n;

  logic                mem_en_n;
  logic [AWIDTH-1:0]   mem_addr1_n, mem_addr2_n;
  logic [DWIDTH-1:0]   m_data_n;
  logic                m_valid_n, m_last_n, busy_n, done_n;

  // Next-state and next-output logic. Every output is a register loaded from
  // the state being entered, so each output is already correct in the first
  // cycle of its state. The port-1 word goes directly into the m_data register,
  // so that register also serves as the port-1 buffer. Only the port-2 word
  // needs a separate holding register. The exceptions are done and busy.
  // The done pulse and the fall of busy come from the cycle spent in DONE, so
  // they become visible in the cycle after it.
  always_comb begin
    state_n     = state_q;
    addr_n      = addr_q;
    remaining_n = remaining_q;
    buf2_n      = buf2_q;
    m_data_n    = m_data;
    mem_addr1_n = mem_addr1;
    mem_addr2_n = mem_addr2;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (pair_count == '0) begin
            state_n = DONE;
          end else begin
            state_n     = FETCH;
            addr_n      = base_addr;
            remaining_n = pair_count;
          end
        end
      end
      FETCH: begin
        state_n = CAPTURE;
      end
      CAPTURE: begin
        state_n  = SEND1;
        m_data_n = mem_data1;
        buf2_n   = mem_data2;
      end
      SEND1: begin
        if (m_ready) begin
          state_n  = SEND2;
          m_data_n = buf2_q;
        end
      end
      SEND2: begin
        if (m_ready) begin
          if (remaining_q == CWIDTH'(1)) begin
            state_n = DONE;
          end else begin
            state_n     = FETCH;
            remaining_n = remaining_q - CWIDTH'(1);
            addr_n      = addr_q + AWIDTH'(2);
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // The addresses change only when a fetch is issued. Otherwise they keep
    // the last pair that was read.
    if (state_n == FETCH) begin
      mem_addr1_n = addr_n;
      mem_addr2_n = addr_n + AWIDTH'(1);
    end

    mem_en_n  = (state_n == FETCH);
    m_valid_n = (state_n == SEND1) || (state_n == SEND2);
    m_last_n  = (state_n == SEND2) && (remaining_n == CWIDTH'(1));
    busy_n    = (state_n != IDLE);
    done_n    = (state_q == DONE);
  end

  // State, bookkeeping and output registers. Reset clears everything and
  // abandons any transfer in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      buf2_q      <= '0;
      mem_en      <= 1'b0;
      mem_addr1   <= '0;
      mem_addr2   <= '0;
      m_data      <= '0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_n;
      addr_q      <= addr_n;
      remaining_q <= remaining_n;
      buf2_q      <= buf2_n;
      mem_en      <= mem_en_n;
      mem_addr1   <= mem_addr1_n;
      mem_addr2   <= mem_addr2_n;
      m_data      <= m_data_n;
      m_valid     <= m_valid_n;
      m_last      <= m_last_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

endmodule

// File: tb/tb_result_reader.sv
// ---------------------------------------------------------------------------
// tb_result_reader
//
// Directed bench for result_reader. A behavioural dual-port memory returns
// registered read data. Each scenario task drives one transfer and compares
// what it observes against hand-computed values.
// ---------------------------------------------------------------------------
module tb_result_reader;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] pair_count;
  logic          mem_en;
  logic [AW-1:0] mem_addr1, mem_addr2;
  logic [DW-1:0] mem_data1, mem_data2;
  logic [DW-1:0] m_data;
  logic          m_valid, m_ready, m_last, busy, done;

  int checks = 0;
  int fails  = 0;

  logic [DW-1:0]     mem [0:255];
  logic [DW-1:0]     words[$];
  logic              lasts[$];
  logic [2*AW-1:0]   fetches[$];
  int done_cnt, busy_cycles, valid_cycles, memen_cycles, stall_viol;
  int first_valid, done_at;
  bit timed_out;

  result_reader #(
    .DWIDTH(DW),
    .frac  (24),
    .AWIDTH(AW),
    .CWIDTH(CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .pair_count(pair_count),
    .mem_en    (mem_en),
    .mem_addr1 (mem_addr1),
    .mem_addr2 (mem_addr2),
    .mem_data1 (mem_data1),
    .mem_data2 (mem_data2),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done)
  );

  // 100 MHz free-running clock
  always #5 clk = ~clk;

  // Memory with registered read ports. Data appears the cycle after mem_en.
  always @(posedge clk) begin
    if (mem_en) begin
      mem_data1 <= mem[mem_addr1];
      mem_data2 <= mem[mem_addr2];
    end
  end

  // Advance one cycle and settle just after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one start and runs the transfer while recording beats, fetches,
  // busy/done activity and stall-stability violations.
  // mode 0 : m_ready held high
  // mode 1 : m_ready toggles, with a 5-cycle stall on the first SEND2 word
  // mode 2 : m_ready high, with extra start pulses and new inputs while busy
  task automatic run_xfer(input logic [AW-1:0] base, input logic [CW-1:0] cnt,
                          input int mode, input int budget);
    logic          pv;
    logic          pr;
    logic [DW-1:0] pd;
    logic          pl;
    int            hold;
    int            c;
    pv = 1'b0; pr = 1'b0; pd = '0; pl = 1'b0; hold = 0;
    words.delete(); lasts.delete(); fetches.delete();
    done_cnt = 0; busy_cycles = 0; valid_cycles = 0; memen_cycles = 0;
    stall_viol = 0; first_valid = -1; done_at = -1; timed_out = 1'b0;
    base_addr  = base;
    pair_count = cnt;
    m_ready    = 1'b1;
    start      = 1'b1;
    step();
    start = 1'b0;
    c = 1;
    while (c < budget) begin
      if (pv && !pr && (!m_valid || m_data !== pd || m_last !== pl)) stall_viol++;
      if (mem_en) begin
        memen_cycles++;
        fetches.push_back({mem_addr1, mem_addr2});
      end
      if (busy) busy_cycles++;
      if (m_valid) begin
        valid_cycles++;
        if (first_valid < 0) first_valid = c;
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (done_at >= 0 && c >= done_at + 3) break;
      case (mode)
        1: begin
          if (m_valid && words.size() == 1 && hold < 5) begin
            m_ready = 1'b0;
            hold++;
          end else begin
            m_ready = (c % 2 == 1);
          end
        end
        2: begin
          m_ready    = 1'b1;
          start      = busy && (c % 3 == 0);
          base_addr  = 8'h40;
          pair_count = 8'd5;
        end
        default: m_ready = 1'b1;
      endcase
      if (m_valid && m_ready) begin
        words.push_back(m_data);
        lasts.push_back(m_last);
      end
      pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
      step();
      c++;
    end
    start   = 1'b0;
    m_ready = 1'b0;
    if (done_at < 0) timed_out = 1'b1;
  endtask

  // Outputs must be zero while reset is held
  task automatic test_reset();
    rst = 1'b0; start = 1'b0; m_ready = 1'b0; base_addr = '0; pair_count = '0;
    step(); step();
    checks++;
    if ({mem_en, m_valid, m_last, busy, done} !== 5'b0) begin
      fails++;
      $display("[TB] FAIL reset_ctrl: got %b want 00000", {mem_en, m_valid, m_last, busy, done});
    end
    checks++;
    if ({m_data, mem_addr1, mem_addr2} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_data: got %h/%h/%h want 0", m_data, mem_addr1, mem_addr2);
    end
    rst = 1'b1;
    step();
  endtask

  // Two pairs with m_ready high: order, m_last, latency, done and busy
  task automatic test_basic();
    logic [DW-1:0] exp [4] = '{32'h01000000, 32'hFF000000, 32'h00800000, 32'h7FFFFFFF};
    run_xfer(8'h10, 8'd2, 0, 60);
    checks++;
    if (timed_out) begin fails++; $display("[TB] FAIL basic_timeout: got no done want done"); end
    checks++;
    if (words.size() !== 4) begin
      fails++; $display("[TB] FAIL basic_count: got %0d want 4", words.size());
    end
    for (int i = 0; i < 4 && i < words.size(); i++) begin
      checks++;
      if (words[i] !== exp[i] || lasts[i] !== (i == 3)) begin
        fails++;
        $display("[TB] FAIL basic_word%0d: got %h last=%b want %h last=%b", i, words[i], lasts[i], exp[i], i == 3);
      end
    end
    checks++;
    if (fetches.size() !== 2 || fetches[0] !== 16'h1011 || fetches[1] !== 16'h1213) begin
      fails++; $display("[TB] FAIL basic_fetch: got %0d fetches want 1011,1213", fetches.size());
    end
    checks++;
    if (first_valid !== 3) begin
      fails++; $display("[TB] FAIL basic_latency: got %0d want 3", first_valid);
    end
    checks++;
    if (done_at !== 10 || done_cnt !== 1) begin
      fails++; $display("[TB] FAIL basic_done: got at %0d cnt %0d want at 10 cnt 1", done_at, done_cnt);
    end
    checks++;
    if (busy !== 1'b0 || busy_cycles !== 9) begin
      fails++; $display("[TB] FAIL basic_busy: got %b/%0d want 0/9", busy, busy_cycles);
    end
  endtask

  // Same transfer with toggling m_ready and a long SEND2 stall
  task automatic test_backpressure();
    logic [DW-1:0] exp [4] = '{32'h01000000, 32'hFF000000, 32'h00800000, 32'h7FFFFFFF};
    run_xfer(8'h10, 8'd2, 1, 100);
    checks++;
    if (timed_out) begin fails++; $display("[TB] FAIL bp_timeout: got no done want done"); end
    checks++;
    if (stall_viol !== 0) begin
      fails++; $display("[TB] FAIL bp_stable: got %0d violations want 0", stall_viol);
    end
    checks++;
    if (words.size() !== 4) begin
      fails++; $display("[TB] FAIL bp_count: got %0d want 4", words.size());
    end
    for (int i = 0; i < 4 && i < words.size(); i++) begin
      checks++;
      if (words[i] !== exp[i] || lasts[i] !== (i == 3)) begin
        fails++;
        $display("[TB] FAIL bp_word%0d: got %h last=%b want %h last=%b", i, words[i], lasts[i], exp[i], i == 3);
      end
    end
    checks++;
    if (done_cnt !== 1) begin
      fails++; $display("[TB] FAIL bp_done: got %0d want 1", done_cnt);
    end
  endtask

  // pair_count = 0: no reads, no beats, done two cycles after start
  task automatic test_zero_count();
    run_xfer(8'h10, 8'd0, 0, 20);
    checks++;
    if (memen_cycles !== 0 || valid_cycles !== 0) begin
      fails++; $display("[TB] FAIL zero_activity: got mem_en %0d valid %0d want 0 0", memen_cycles, valid_cycles);
    end
    checks++;
    if (done_at !== 2 || done_cnt !== 1) begin
      fails++; $display("[TB] FAIL zero_done: got at %0d cnt %0d want at 2 cnt 1", done_at, done_cnt);
    end
    checks++;
    if (busy_cycles !== 1) begin
      fails++; $display("[TB] FAIL zero_busy: got %0d want 1", busy_cycles);
    end
  endtask

  // Addresses wrap past 0xFF; starts and input changes while busy are ignored
  task automatic test_wrap();
    logic [DW-1:0] exp [4] = '{32'hC00000FF, 32'hC0000000, 32'hC0000001, 32'hC0000002};
    run_xfer(8'hFF, 8'd2, 2, 60);
    checks++;
    if (fetches.size() !== 2 || fetches[0] !== 16'hFF00 || fetches[1] !== 16'h0102) begin
      fails++; $display("[TB] FAIL wrap_fetch: got %0d fetches want FF00,0102", fetches.size());
    end
    checks++;
    if (words.size() !== 4) begin
      fails++; $display("[TB] FAIL wrap_count: got %0d want 4", words.size());
    end
    for (int i = 0; i < 4 && i < words.size(); i++) begin
      checks++;
      if (words[i] !== exp[i]) begin
        fails++; $display("[TB] FAIL wrap_word%0d: got %h want %h", i, words[i], exp[i]);
      end
    end
    checks++;
    if (done_cnt !== 1 || busy !== 1'b0) begin
      fails++; $display("[TB] FAIL wrap_done: got cnt %0d busy %b want 1 0", done_cnt, busy);
    end
  endtask

  // Reset asserted in SEND1 of the first pair, then a clean one-pair transfer
  task automatic test_reset_mid();
    int dones;
    dones = 0;
    base_addr = 8'h30; pair_count = 8'd3; m_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'hC0000030 || busy !== 1'b1) begin
      fails++; $display("[TB] FAIL rmid_send1: got v=%b %h busy=%b want 1 C0000030 1", m_valid, m_data, busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({mem_en, m_valid, m_last, busy, done} !== 5'b0 || m_data !== '0 || mem_addr1 !== '0) begin
      fails++; $display("[TB] FAIL rmid_async: got %b data %h want 00000 data 0", {mem_en, m_valid, m_last, busy, done}, m_data);
    end
    step(); step();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (done || busy) dones++;
      step();
    end
    checks++;
    if (dones !== 0) begin
      fails++; $display("[TB] FAIL rmid_nodone: got %0d done/busy cycles want 0", dones);
    end
    run_xfer(8'h20, 8'd1, 0, 40);
    checks++;
    if (words.size() !== 2 || fetches.size() !== 1) begin
      fails++; $display("[TB] FAIL rmid_after_count: got %0d words %0d fetches want 2 1", words.size(), fetches.size());
    end else begin
      checks++;
      if (words[0] !== 32'hC0000020 || words[1] !== 32'hC0000021 || lasts[0] !== 1'b0 ||
          lasts[1] !== 1'b1 || fetches[0] !== 16'h2021) begin
        fails++;
        $display("[TB] FAIL rmid_after_data: got %h %h last %b%b fetch %h want C0000020 C0000021 last 01 fetch 2021",
                 words[0], words[1], lasts[0], lasts[1], fetches[0]);
      end
    end
    checks++;
    if (done_cnt !== 1) begin
      fails++; $display("[TB] FAIL rmid_after_done: got %0d want 1", done_cnt);
    end
  endtask

  // Scenario sequence
  initial begin
    mem_data1 = '0;
    mem_data2 = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0000000 | i;
    mem[8'h10] = 32'h01000000;
    mem[8'h11] = 32'hFF000000;
    mem[8'h12] = 32'h00800000;
    mem[8'h13] = 32'h7FFFFFFF;
    $display("[TB] starting result_reader bench");
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_count();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/result_reader.md
Name: result_reader

Overview:
- Read-side counterpart of the dual-port result memory that the forward pass fills two words per cycle (out1/out2 pairs).
- Fetches N stored word pairs from consecutive address pairs, buffers each pair, and streams the words out one per beat on a valid/ready interface: port-1 word first, then port-2 word.
- Sits between the result memory and the host/debug or backward-pass consumer.

Parameters:
- DWIDTH, 32, data word width (signed fixed-point, passed through unmodified).
- frac, 24, fractional bits of the data format (informational only; no arithmetic on data).
- AWIDTH, 8, memory address width.
- CWIDTH, 8, width of the pair-count input.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a transfer; sampled only in IDLE.
- base_addr  in  AWIDTH  first address; the first pair is base_addr / base_addr+1.
- pair_count  in  CWIDTH  number of pairs to transfer; 0 is legal.
- mem_en  out  1  memory read enable.
- mem_addr1  out  AWIDTH  port-1 read address.
- mem_addr2  out  AWIDTH  port-2 read address.
- mem_data1  in  DWIDTH  port-1 read data; valid the cycle after mem_en.
- mem_data2  in  DWIDTH  port-2 read data; valid the cycle after mem_en.
- m_data  out  DWIDTH  output word.
- m_valid  out  1  output word valid.
- m_ready  in  1  consumer accepts the word when m_valid & m_ready.
- m_last  out  1  marks the final word of a transfer.
- busy  out  1  high from start acceptance until DONE.
- done  out  1  one-cycle pulse at transfer end.

Behaviour:
- All outputs registered.
- Reset (rst=0, asynchronous) forces state IDLE and all outputs to 0. Internal address, count and buffer registers also clear to 0. Reset mid-transfer abandons the transfer; no done pulse follows.
- States: IDLE, FETCH, CAPTURE, SEND1, SEND2, DONE.
- IDLE
  - start=1 with pair_count=0: go to DONE (no memory reads, no beats).
  - start=1 with pair_count>0: latch addr=base_addr, remaining=pair_count, set busy=1, go to FETCH.
- FETCH (1 cycle)
  - mem_en=1, mem_addr1=addr, mem_addr2=addr+1 (mod 2^AWIDTH).
  - Go to CAPTURE.
- CAPTURE (1 cycle)
  - mem_en=0. Latch buf1=mem_data1, buf2=mem_data2. Go to SEND1.
- SEND1
  - m_valid=1, m_data=buf1, m_last=0.
  - On handshake go to SEND2.
- SEND2
  - m_valid=1, m_data=buf2, m_last=1 iff remaining==1.
  - On handshake with remaining==1: go to DONE.
  - On handshake otherwise: decrement remaining, addr=addr+2 (mod 2^AWIDTH), go to FETCH.
- DONE (1 cycle)
  - done=1, busy=0, m_valid=0. Go to IDLE.
- Handshake rules:
  - m_valid never deasserts and m_data/m_last never change while m_valid=1 and m_ready=0.
  - m_valid is not conditioned on m_ready.
  - m_valid=0 in every state except SEND1/SEND2.
- start is ignored outside IDLE. busy stays high throughout, including while stalled by m_ready=0.
- Address arithmetic wraps modulo 2^AWIDTH. Example: base_addr=8'hFF gives addr1=FF, addr2=00, then next pair 01/02.
- mem_addr1/mem_addr2 hold their last values while mem_en=0.
- Latency:
  - start to first m_valid: 3 cycles (FETCH, CAPTURE, SEND1 registered).
  - Steady throughput with m_ready held high: 2 words per 4 cycles.
- pair_count is sampled only at start acceptance; later changes have no effect.

Test Plan:
- Basic transfer: memory [0x10]=0x01000000, [0x11]=0xFF000000, [0x12]=0x00800000, [0x13]=0x7FFFFFFF; base_addr=0x10, pair_count=2, m_ready=1.
  - Required: words 0x01000000, 0xFF000000, 0x00800000, 0x7FFFFFFF, with m_last only on the 4th.
  - Required: one done pulse after the last beat; busy low afterwards.
- Backpressure: same transfer, m_ready toggled 0/1 every cycle, plus held 0 for 5 cycles during SEND2.
  - Required: m_data/m_valid/m_last stable while stalled; identical 4-word sequence; no duplicate or dropped words.
- Zero count: pair_count=0 with start.
  - Required: mem_en never asserted, m_valid never asserted, done pulses 2 cycles after start, busy high 1 cycle.
- Address wrap: base_addr=0xFF, pair_count=2.
  - Required: fetches (FF,00) then (01,02).
  - Required: start pulses during the transfer are ignored.
- Reset mid-transfer: rst=0 asserted while in SEND1 of pair 1 of 3.
  - Required: outputs clear immediately, asynchronously; no done pulse.
  - Required: a subsequent start with base_addr=0x20, pair_count=1 runs cleanly from 0x20/0x21.
